ticket_vend_ctrl: RTL and testbench
===================================

TICKET_VEND_CTRL -- requirements
Module: ticket_vend_ctrl

Interface
REQ-001 SHALL have parameter CREDIT_W, default 8, credit/change width in coin units.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, inactivity limit in PAY (used only with TVM_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port scan_rdy  input  1  key-code valid from button_scan (out_RDY1).
REQ-006 SHALL have port scan_data  input  8  one-hot key code from button_scan (DATA_out1).
REQ-007 SHALL have port scan_ack  output  1  one-cycle pulse: key code consumed.
REQ-008 SHALL have port coin_valid  input  1  one-cycle coin-inserted strobe.
REQ-009 SHALL have port coin_type  input  2  coin value: 0=5, 1=10, 2=20, 3=50.
REQ-010 SHALL have port coin_reject  output  1  one-cycle pulse: coin returned uncredited.
REQ-011 SHALL have port ticket_dispense  output  1  one-cycle pulse: release ticket.
REQ-012 SHALL have port ticket_id  output  2  ticket type; valid while ticket_dispense=1.
REQ-013 SHALL have port change_valid  output  1  one-cycle pulse: pay out change_amt.
REQ-014 SHALL have port change_amt  output  CREDIT_W  change/refund amount; valid while change_valid=1.
REQ-015 SHALL have port credit  output  CREDIT_W  current accumulated credit.
REQ-016 SHALL have port state_out  output  3  current FSM state encoding.

Function
REQ-017 SHALL implement states IDLE, PAY, DISPENSE, CHANGE.
REQ-018 SHALL decode scan_data: bits 0-3 select ticket 0-3 (prices 10/20/50/100), bit 4 cancel, bit 5 confirm-reserved (ignored); non-one-hot codes ignored.
REQ-019 SHALL pulse scan_ack the cycle after every scan_rdy=1 sample, including ignored codes, in every state.
REQ-020 IDLE: valid select latches ticket_id and price, credit=0, next PAY; cancel ignored; coin rejected.
REQ-021 PAY: valid coin adds its value to credit next cycle; if credit+coin > 2^CREDIT_W-1, coin_reject pulses and credit is unchanged.
REQ-022 PAY: when credit >= price, next state DISPENSE (one cycle after credit update).
REQ-023 PAY: another select code ignored; cancel goes to CHANGE with change_amt=credit, no ticket.
REQ-024 PAY: simultaneous cancel and coin_valid -> cancel taken, coin rejected.
REQ-025 DISPENSE: ticket_dispense pulses for exactly one cycle, next CHANGE.
REQ-026 CHANGE: if remaining amount (credit-price, or credit on cancel) > 0, change_valid pulses one cycle with that amount; otherwise no pulse; credit cleared, next IDLE.
REQ-027 DISPENSE/CHANGE: coin_valid -> coin_reject; keys acked and ignored.
REQ-028 Select to ticket with exact credit: ticket_dispense exactly 2 cycles after credit-completing coin strobe.

Reset
REQ-029 On rst=0, state=IDLE, credit=0, latched ticket/price=0, all pulse outputs=0, change_amt=0, ticket_id=0, timers=0, asynchronously.
REQ-030 Reset mid-transaction SHALL discard credit without change_valid or ticket_dispense.
REQ-031 Deassertion SHALL be synchronised externally; first active edge after release processes inputs normally.

Configuration
REQ-032 With TVM_TIMEOUT_EN defined: counter counts cycles in PAY, cleared by any coin or key; at TIMEOUT_CYCLES behaves as cancel (refund credit, or plain return to IDLE via CHANGE if credit=0).
REQ-033 Without TVM_TIMEOUT_EN: no counter logic; PAY held indefinitely.

Structure
REQ-034 Shared package tvm_pkg SHALL hold state enum, key-bit positions, coin values, ticket price constants.
REQ-035 Sub-module tvm_price_rom (ticket_id -> price, combinational) SHALL be instantiated; FSM in top.

Verification
REQ-036 rst released; key 0000_0100 (ticket 2) then coins 50 -> ticket_dispense with ticket_id=2 two cycles after coin, no change_valid.
REQ-037 Key 0000_0001 (ticket 0, price 10), coin 20 -> ticket_dispense, then change_valid with change_amt=10.
REQ-038 Ticket 3, coins 50 then 20, key 0001_0000 (cancel) -> change_valid, change_amt=70, no ticket_dispense.
REQ-039 Ticket 3, coin 50 and cancel same cycle -> coin_reject, refund change_amt=0 suppressed (no pulse), state IDLE.
REQ-040 Key 0000_0011 and coin in IDLE -> scan_ack pulse, coin_reject pulse, state stays IDLE, credit=0.
REQ-041 TVM_TIMEOUT_EN, TIMEOUT_CYCLES=16: ticket 1, coin 10, no activity 16 cycles -> change_valid change_amt=10, IDLE; reset mid-PAY -> credit=0, no pulses.

Source files
------------

// File: rtl/tvm_pkg.sv
// Shared definitions for the ticket vending controller: FSM state encoding,
// key-code bit positions, coin values and ticket prices (all in coin units).
package tvm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PAY      = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_CHANGE   = 3'd3
  } state_t;

  // Key-code bit positions in the one-hot scan_data word
  localparam int KEY_SEL_LO  = 0;  // bits 0..3 select tickets 0..3
  localparam int KEY_SEL_HI  = 3;
  localparam int KEY_CANCEL  = 4;
  localparam int KEY_CONFIRM = 5;  // reserved, never acted on

  // Coin values indexed by coin_type
  localparam int unsigned COIN_VAL0 = 5;
  localparam int unsigned COIN_VAL1 = 10;
  localparam int unsigned COIN_VAL2 = 20;
  localparam int unsigned COIN_VAL3 = 50;

  // Ticket prices indexed by ticket_id
  localparam int unsigned PRICE_T0 = 10;
  localparam int unsigned PRICE_T1 = 20;
  localparam int unsigned PRICE_T2 = 50;
  localparam int unsigned PRICE_T3 = 100;

  function automatic int unsigned coin_value(input logic [1:0] coin_type);
    case (coin_type)
      2'd0:    coin_value = COIN_VAL0;
      2'd1:    coin_value = COIN_VAL1;
      2'd2:    coin_value = COIN_VAL2;
      default: coin_value = COIN_VAL3;
    endcase
  endfunction

endpackage

// File: rtl/tvm_price_rom.sv
// Combinational ticket price lookup: ticket_id -> price in coin units.
module tvm_price_rom
  import tvm_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [1:0]          ticket_id,
  output logic [CREDIT_W-1:0] price
);

  // Constant table lookup
  always_comb begin
    case (ticket_id)
      2'd0:    price = CREDIT_W'(PRICE_T0);
      2'd1:    price = CREDIT_W'(PRICE_T1);
      2'd2:    price = CREDIT_W'(PRICE_T2);
      default: price = CREDIT_W'(PRICE_T3);
    endcase
  end

endmodule

// File: rtl/ticket_vend_ctrl.sv
// Ticket vending machine controller: takes one-hot key codes from the button
// scanner and coin strobes, accumulates credit, releases the ticket and pays
// out change or a refund. All outputs are registered.
// Optional build macro TVM_TIMEOUT_EN adds an inactivity timeout in PAY that
// behaves like a cancel after TIMEOUT_CYCLES idle cycles.
module ticket_vend_ctrl
  import tvm_pkg::*;
#(
  parameter int CREDIT_W       = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_rdy,
  input  logic [7:0]          scan_data,
  output logic                scan_ack,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  output logic                coin_reject,
  output logic                ticket_dispense,
  output logic [1:0]          ticket_id,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [CREDIT_W-1:0] credit,
  output logic [2:0]          state_out
);

  state_t              state;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] rom_price;
  logic [1:0]          sel_id;
  logic                key_valid;
  logic                sel_valid;
  logic                cancel;
  logic                timeout;
  logic [CREDIT_W:0]   credit_sum;
  logic                overflow;
  logic [CREDIT_W-1:0] remaining;

  // Key decode: only a single set bit counts as a key; bit 5 and bits 6-7 fall through
  always_comb begin
    key_valid = scan_rdy && $onehot(scan_data);
    sel_valid = key_valid && (|scan_data[KEY_SEL_HI:KEY_SEL_LO]);
    cancel    = key_valid && scan_data[KEY_CANCEL];
    if (scan_data[KEY_SEL_LO+1])      sel_id = 2'd1;
    else if (scan_data[KEY_SEL_LO+2]) sel_id = 2'd2;
    else if (scan_data[KEY_SEL_LO+3]) sel_id = 2'd3;
    else                              sel_id = 2'd0;
  end

  tvm_price_rom #(.CREDIT_W(CREDIT_W)) u_price_rom (
    .ticket_id (sel_id),
    .price     (rom_price)
  );

  // Credit arithmetic one bit wider so a coin that would wrap can be refused
  always_comb begin
    credit_sum = {1'b0, credit} + (CREDIT_W+1)'(coin_value(coin_type));
    overflow   = credit_sum[CREDIT_W];
    remaining  = credit - price;
  end

`ifdef TVM_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_W-1:0] timer;
  logic               activity;

  assign activity = coin_valid || scan_rdy;
  assign timeout  = (state == ST_PAY) && !activity &&
                    (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  // Inactivity counter: runs only in PAY, restarts on any coin or key
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if ((state != ST_PAY) || activity || timeout) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end
`else
  // Without the timeout the limit parameter has no effect and PAY waits forever
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

  assign state_out = state;

  // Main FSM with registered pulse and data outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      credit          <= '0;
      price           <= '0;
      ticket_id       <= 2'd0;
      scan_ack        <= 1'b0;
      coin_reject     <= 1'b0;
      ticket_dispense <= 1'b0;
      change_valid    <= 1'b0;
      change_amt      <= '0;
    end else begin
      scan_ack        <= scan_rdy;
      coin_reject     <= 1'b0;
      ticket_dispense <= 1'b0;
      change_valid    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            ticket_id <= sel_id;
            price     <= rom_price;
            credit    <= '0;
            state     <= ST_PAY;
          end
          if (coin_valid) coin_reject <= 1'b1;
        end
        ST_PAY: begin
          if (cancel || timeout) begin
            change_valid <= (credit != '0);
            change_amt   <= credit;
            state        <= ST_CHANGE;
            if (coin_valid) coin_reject <= 1'b1;
          end else if (credit >= price) begin
            ticket_dispense <= 1'b1;
            state           <= ST_DISPENSE;
            if (coin_valid) coin_reject <= 1'b1;
          end else if (coin_valid) begin
            if (overflow) coin_reject <= 1'b1;
            else          credit      <= credit_sum[CREDIT_W-1:0];
          end
        end
        ST_DISPENSE: begin
          change_valid <= (remaining != '0);
          change_amt   <= remaining;
          state        <= ST_CHANGE;
          if (coin_valid) coin_reject <= 1'b1;
        end
        ST_CHANGE: begin
          credit <= '0;
          state  <= ST_IDLE;
          if (coin_valid) coin_reject <= 1'b1;
        end
        default: begin
          credit <= '0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Directed self-checking bench for ticket_vend_ctrl. Uses CREDIT_W=7 so the
// coin-overflow refusal is reachable, and TIMEOUT_CYCLES=16 for timeout builds.
module tb_ticket_vend_ctrl;

  localparam int CW = 7;

  logic          clk;
  logic          rst = 1'b1;
  logic          scan_rdy;
  logic [7:0]    scan_data;
  logic          scan_ack;
  logic          coin_valid;
  logic [1:0]    coin_type;
  logic          coin_reject;
  logic          ticket_dispense;
  logic [1:0]    ticket_id;
  logic          change_valid;
  logic [CW-1:0] change_amt;
  logic [CW-1:0] credit;
  logic [2:0]    state_out;

  int checks   = 0;
  int failures = 0;

  ticket_vend_ctrl #(.CREDIT_W(CW), .TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .scan_rdy        (scan_rdy),
    .scan_data       (scan_data),
    .scan_ack        (scan_ack),
    .coin_valid      (coin_valid),
    .coin_type       (coin_type),
    .coin_reject     (coin_reject),
    .ticket_dispense (ticket_dispense),
    .ticket_id       (ticket_id),
    .change_valid    (change_valid),
    .change_amt      (change_amt),
    .credit          (credit),
    .state_out       (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [7:0] code);
    scan_rdy  = 1'b1;
    scan_data = code;
    tick();
    scan_rdy  = 1'b0;
    scan_data = 8'h00;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    tick();
    coin_valid = 1'b0;
  endtask

  initial begin
    scan_rdy   = 1'b0;
    scan_data  = 8'h00;
    coin_valid = 1'b0;
    coin_type  = 2'd0;

    // Reset state
    #3 rst = 1'b0;
    #1;
    chk("rst_state", 32'(state_out), 0);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_pulses", 32'({scan_ack, coin_reject, ticket_dispense, change_valid}), 0);
    chk("rst_change_amt", 32'(change_amt), 0);
    chk("rst_ticket_id", 32'(ticket_id), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("idle_after_rst", 32'(state_out), 0);

    // Ticket 2 (price 50), exact coin 50
    key(8'h04);
    chk("t2_state_pay", 32'(state_out), 1);
    chk("t2_scan_ack", 32'(scan_ack), 1);
    chk("t2_ticket_id", 32'(ticket_id), 2);
    coin(2'd3);
    chk("t2_credit", 32'(credit), 50);
    chk("t2_no_disp_yet", 32'(ticket_dispense), 0);
    tick();
    chk("t2_dispense", 32'(ticket_dispense), 1);
    chk("t2_state_disp", 32'(state_out), 2);
    chk("t2_disp_id", 32'(ticket_id), 2);
    tick();
    chk("t2_disp_one_cycle", 32'(ticket_dispense), 0);
    chk("t2_state_change", 32'(state_out), 3);
    chk("t2_no_change", 32'(change_valid), 0);
    tick();
    chk("t2_state_idle", 32'(state_out), 0);
    chk("t2_credit_clr", 32'(credit), 0);
    chk("t2_no_change2", 32'(change_valid), 0);

    // Ticket 0 (price 10), coin 20 -> change 10
    key(8'h01);
    chk("t0_ticket_id", 32'(ticket_id), 0);
    coin(2'd2);
    chk("t0_credit", 32'(credit), 20);
    tick();
    chk("t0_dispense", 32'(ticket_dispense), 1);
    tick();
    chk("t0_change_valid", 32'(change_valid), 1);
    chk("t0_change_amt", 32'(change_amt), 10);
    tick();
    chk("t0_change_one_cycle", 32'(change_valid), 0);
    chk("t0_idle", 32'(state_out), 0);
    chk("t0_credit_clr", 32'(credit), 0);

    // Ticket 3, coins 50 + 20, cancel -> refund 70
    key(8'h08);
    coin(2'd3);
    coin(2'd2);
    chk("c_credit", 32'(credit), 70);
    key(8'h10);
    chk("c_state_change", 32'(state_out), 3);
    chk("c_change_valid", 32'(change_valid), 1);
    chk("c_change_amt", 32'(change_amt), 70);
    chk("c_no_dispense", 32'(ticket_dispense), 0);
    tick();
    chk("c_idle", 32'(state_out), 0);
    chk("c_credit_clr", 32'(credit), 0);
    chk("c_no_dispense2", 32'(ticket_dispense), 0);

    // Ticket 3, cancel together with coin 50 -> coin rejected, no refund pulse
    key(8'h08);
    scan_rdy   = 1'b1;
    scan_data  = 8'h10;
    coin_valid = 1'b1;
    coin_type  = 2'd3;
    tick();
    scan_rdy   = 1'b0;
    scan_data  = 8'h00;
    coin_valid = 1'b0;
    chk("cc_coin_reject", 32'(coin_reject), 1);
    chk("cc_state_change", 32'(state_out), 3);
    chk("cc_no_change", 32'(change_valid), 0);
    chk("cc_credit", 32'(credit), 0);
    tick();
    chk("cc_idle", 32'(state_out), 0);
    chk("cc_no_change2", 32'(change_valid), 0);

    // Non-one-hot key and coin while idle
    scan_rdy   = 1'b1;
    scan_data  = 8'h03;
    coin_valid = 1'b1;
    coin_type  = 2'd0;
    tick();
    scan_rdy   = 1'b0;
    scan_data  = 8'h00;
    coin_valid = 1'b0;
    chk("i_scan_ack", 32'(scan_ack), 1);
    chk("i_coin_reject", 32'(coin_reject), 1);
    chk("i_state_idle", 32'(state_out), 0);
    chk("i_credit", 32'(credit), 0);
    tick();
    chk("i_ack_one_cycle", 32'(scan_ack), 0);
    chk("i_reject_one_cycle", 32'(coin_reject), 0);

    // Cancel while idle is ignored
    key(8'h10);
    chk("ic_state_idle", 32'(state_out), 0);
    chk("ic_ack", 32'(scan_ack), 1);

    // Overflow at CREDIT_W=7: 95 + 50 > 127 is refused
    key(8'h08);
    coin(2'd3);
    coin(2'd2);
    coin(2'd2);
    coin(2'd0);
    chk("ov_credit95", 32'(credit), 95);
    coin(2'd3);
    chk("ov_reject", 32'(coin_reject), 1);
    chk("ov_credit_kept", 32'(credit), 95);
    chk("ov_state_pay", 32'(state_out), 1);
    coin(2'd0);
    chk("ov_credit100", 32'(credit), 100);
    chk("ov_no_reject", 32'(coin_reject), 0);
    tick();
    chk("ov_dispense", 32'(ticket_dispense), 1);
    chk("ov_ticket_id", 32'(ticket_id), 3);
    coin(2'd1);
    chk("ov_disp_coin_reject", 32'(coin_reject), 1);
    chk("ov_no_change", 32'(change_valid), 0);
    tick();
    chk("ov_idle", 32'(state_out), 0);

    // Second select in PAY ignored; cancel with zero credit gives no pulse
    key(8'h02);
    key(8'h08);
    chk("ps_ticket_id", 32'(ticket_id), 1);
    chk("ps_state_pay", 32'(state_out), 1);
    key(8'h20);
    chk("ps_confirm_ignored", 32'(state_out), 1);
    key(8'h10);
    chk("ps_state_change", 32'(state_out), 3);
    chk("ps_no_change", 32'(change_valid), 0);
    tick();
    chk("ps_idle", 32'(state_out), 0);

`ifdef TVM_TIMEOUT_EN
    // Timeout: ticket 1, coin 10, then 16 idle cycles -> refund 10
    begin
      int waited;
      key(8'h02);
      coin(2'd1);
      waited = 0;
      while (!change_valid && waited < 40) begin
        tick();
        waited++;
      end
      chk("to_wait_cycles", 32'(waited), 16);
      chk("to_change_valid", 32'(change_valid), 1);
      chk("to_change_amt", 32'(change_amt), 10);
      tick();
      chk("to_idle", 32'(state_out), 0);
    end
`else
    // No timeout: PAY is held indefinitely
    key(8'h02);
    coin(2'd1);
    repeat (40) tick();
    chk("nt_state_pay", 32'(state_out), 1);
    chk("nt_credit", 32'(credit), 10);
    chk("nt_no_change", 32'(change_valid), 0);
    key(8'h10);
    chk("nt_refund", 32'(change_amt), 10);
    tick();
`endif

    // Reset mid-PAY discards credit without any pulse
    key(8'h04);
    coin(2'd3);
    chk("r_credit50", 32'(credit), 50);
    #2 rst = 1'b0;
    #1;
    chk("r_async_state", 32'(state_out), 0);
    chk("r_async_credit", 32'(credit), 0);
    tick();
    tick();
    chk("r_no_pulses", 32'({ticket_dispense, change_valid}), 0);
    rst = 1'b1;
    tick();
    tick();
    chk("r_idle", 32'(state_out), 0);
    chk("r_no_pulses2", 32'({ticket_dispense, change_valid}), 0);
    chk("r_credit_clr", 32'(credit), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
